// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline constants: register file geometry defaults
//               and the hardwired-zero register index.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int DEF_DW   = 32;
    localparam int DEF_AW   = 5;
    localparam int DEF_NREG = 32;
    localparam int REG_ZERO = 0;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/regfile_bypass_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_bypass_sb_if
// Description : ID/WB-side bundle of the register file: two read ports with
//               busy flags, one byte-enabled write port and the issue strobe.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_bypass_sb_if
    import pipe_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) ();

    logic [AW-1:0]   rna;
    logic [AW-1:0]   rnb;
    logic [DW-1:0]   qa;
    logic [DW-1:0]   qb;
    logic            busy_a;
    logic            busy_b;
    logic [AW-1:0]   wn;
    logic [DW-1:0]   d;
    logic            we;
    logic [DW/8-1:0] wbe;
    logic            iss;
    logic [AW-1:0]   iss_rn;

    // Pipeline side: drives addresses, write data and issue marks
    modport master (
        output rna, rnb, wn, d, we, wbe, iss, iss_rn,
        input  qa, qb, busy_a, busy_b
    );

    // Register file side
    modport slave (
        input  rna, rnb, wn, d, we, wbe, iss, iss_rn,
        output qa, qb, busy_a, busy_b
    );

endinterface : regfile_bypass_sb_if
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : One pending-write bit per architectural register. Issue sets,
//               write-back clears; a same-register set beats the clear.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import pipe_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int AW   = DEF_AW
) (
    input  wire logic            clk,
    input  wire logic            clrn,
    input  wire logic            set_en,
    input  wire logic [AW-1:0]   set_rn,
    input  wire logic            clr_en,
    input  wire logic [AW-1:0]   clr_rn,
    output logic      [NREG-1:0] busy
);

    logic [NREG-1:0] r_busy;

    // Per-register set/clear; bit 0 is only ever reset and so stays 0
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_busy <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (set_en && (set_rn == AW'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (clr_en && (clr_rn == AW'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    assign busy = r_busy;

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_bypass_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_bypass_sb
// Description : 2-read/1-write register file with byte-enable writes,
//               optional same-cycle write-to-read bypass and a pending-write
//               scoreboard for RAW hazard detection. r0 reads zero, never busy.
//               DW must be a multiple of 8.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_bypass_sb
    import pipe_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int NREG   = DEF_NREG,
    parameter int AW     = DEF_AW,
    parameter int BYPASS = 1
) (
    input  wire logic         clk,
    input  wire logic         clrn,
    regfile_bypass_sb_if.slave bus
);

    localparam int          c_NB   = DW / 8;
    localparam logic [AW:0] c_NREG = (AW+1)'(NREG);
    localparam logic [AW-1:0] c_R0 = AW'(REG_ZERO);

    logic [DW-1:0]   r_mem [NREG];
    logic [NREG-1:0] w_busy;
    logic            w_wr_valid;
    logic            w_iss_valid;
    logic [DW-1:0]   w_st_a;
    logic [DW-1:0]   w_st_b;
    logic            w_hit_a;
    logic            w_hit_b;

    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < c_NREG);
    endfunction

    // Overlay the enabled bytes of the new data onto the old word
    function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0]   old_w,
                                                 input logic [DW-1:0]   new_w,
                                                 input logic [c_NB-1:0] be);
        logic [DW-1:0] m;
        m = old_w;
        for (int k = 0; k < c_NB; k++) begin
            if (be[k]) m[8*k +: 8] = new_w[8*k +: 8];
        end
        return m;
    endfunction

    assign w_wr_valid  = bus.we  && (bus.wn     != c_R0) && in_range(bus.wn);
    assign w_iss_valid = bus.iss && (bus.iss_rn != c_R0) && in_range(bus.iss_rn);

    // Byte-enabled storage; r0 is cleared by reset and never written
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        end else if (w_wr_valid) begin
            for (int k = 0; k < c_NB; k++) begin
                if (bus.wbe[k]) r_mem[bus.wn][8*k +: 8] <= bus.d[8*k +: 8];
            end
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk    (clk),
        .clrn   (clrn),
        .set_en (w_iss_valid),
        .set_rn (bus.iss_rn),
        .clr_en (w_wr_valid),
        .clr_rn (bus.wn),
        .busy   (w_busy)
    );

    // Stored-value read: r0 and out-of-range addresses return zero
    always_comb begin
        w_st_a = '0;
        w_st_b = '0;
        if ((bus.rna != c_R0) && in_range(bus.rna)) w_st_a = r_mem[bus.rna];
        if ((bus.rnb != c_R0) && in_range(bus.rnb)) w_st_b = r_mem[bus.rnb];
    end

    // Bypass hits are gated by clrn so reset shows the cleared state only
    assign w_hit_a = (BYPASS != 0) && clrn && w_wr_valid && (bus.rna == bus.wn);
    assign w_hit_b = (BYPASS != 0) && clrn && w_wr_valid && (bus.rnb == bus.wn);

    // Read muxes; a forwarded write also hides the busy flag it resolves
    always_comb begin
        bus.qa     = w_hit_a ? byte_merge(w_st_a, bus.d, bus.wbe) : w_st_a;
        bus.qb     = w_hit_b ? byte_merge(w_st_b, bus.d, bus.wbe) : w_st_b;
        bus.busy_a = 1'b0;
        bus.busy_b = 1'b0;
        if (in_range(bus.rna)) bus.busy_a = w_busy[bus.rna] && !w_hit_a;
        if (in_range(bus.rnb)) bus.busy_b = w_busy[bus.rnb] && !w_hit_b;
    end

endmodule : regfile_bypass_sb
`default_nettype wire

// File: tb/tb_regfile_bypass_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_bypass_sb
// Description : Directed bench for regfile_bypass_sb. Two instances share
//               stimulus: one with bypass enabled, one without.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_bypass_sb;

    logic clk;
    logic clrn;

    regfile_bypass_sb_if #(.DW(32), .AW(5)) bus1 ();
    regfile_bypass_sb_if #(.DW(32), .AW(5)) bus0 ();

    regfile_bypass_sb #(.DW(32), .NREG(32), .AW(5), .BYPASS(1)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus1.slave)
    );

    regfile_bypass_sb #(.DW(32), .NREG(32), .AW(5), .BYPASS(0)) dut_nb (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] qa;
        logic [31:0] qb;
        logic        ba;
        logic        bb;
        logic [31:0] qa0;
        logic        ba0;
    } exp_t;

    exp_t q_exp[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %h, expected %h", n, f, act, req);
        end
    endtask

    // Monitor: outputs are settled mid-cycle; compare every queued entry
    always @(negedge clk) begin
        exp_t e;
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            chk(e.name, "qa",     bus1.qa,            e.qa);
            chk(e.name, "qb",     bus1.qb,            e.qb);
            chk(e.name, "busy_a", {31'd0, bus1.busy_a}, {31'd0, e.ba});
            chk(e.name, "busy_b", {31'd0, bus1.busy_b}, {31'd0, e.bb});
            chk(e.name, "nb_qa",  bus0.qa,            e.qa0);
            chk(e.name, "nb_busy_a", {31'd0, bus0.busy_a}, {31'd0, e.ba0});
        end
    end

    // Apply one cycle of stimulus just after the edge and queue its expectation
    task automatic step(input string n, input logic rn_c,
                        input logic [4:0] ra, input logic [4:0] rb,
                        input logic w, input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] be,
                        input logic is, input logic [4:0] ir,
                        input logic [31:0] eqa, input logic [31:0] eqb, input logic eba, input logic ebb,
                        input logic [31:0] eqa0, input logic eba0);
        exp_t e;
        @(posedge clk);
        #1;
        clrn = rn_c;
        bus1.rna = ra; bus1.rnb = rb; bus1.we = w; bus1.wn = wa; bus1.d = wd;
        bus1.wbe = be; bus1.iss = is; bus1.iss_rn = ir;
        bus0.rna = ra; bus0.rnb = rb; bus0.we = w; bus0.wn = wa; bus0.d = wd;
        bus0.wbe = be; bus0.iss = is; bus0.iss_rn = ir;
        e.name = n; e.qa = eqa; e.qb = eqb; e.ba = eba; e.bb = ebb; e.qa0 = eqa0; e.ba0 = eba0;
        q_exp.push_back(e);
    endtask

    initial begin
        int wait_cnt;
        clrn = 1'b0;
        bus1.rna = '0; bus1.rnb = '0; bus1.we = 1'b0; bus1.wn = '0; bus1.d = '0;
        bus1.wbe = '0; bus1.iss = 1'b0; bus1.iss_rn = '0;
        bus0.rna = '0; bus0.rnb = '0; bus0.we = 1'b0; bus0.wn = '0; bus0.d = '0;
        bus0.wbe = '0; bus0.iss = 1'b0; bus0.iss_rn = '0;

        //    name          clrn rna rnb we wn  d             wbe    iss rn  qa            qb            ba bb qa0           ba0
        step("rst_hold",    0,   5,  0,  1, 5,  32'hDEADBEEF, 4'hF,  1,  5,  32'h0,        32'h0,        0, 0, 32'h0,        0);
        step("rst_release", 1,   5,  0,  0, 0,  32'h0,        4'h0,  0,  0,  32'h0,        32'h0,        0, 0, 32'h0,        0);
        step("wr_r5_byp",   1,   5,  0,  1, 5,  32'hDEADBEEF, 4'hF,  0,  0,  32'hDEADBEEF, 32'h0,        0, 0, 32'h0,        0);
        step("rd_r5",       1,   5,  0,  0, 0,  32'h0,        4'h0,  0,  0,  32'hDEADBEEF, 32'h0,        0, 0, 32'hDEADBEEF, 0);
        step("rst_mid",     0,   5,  0,  0, 0,  32'h0,        4'h0,  0,  0,  32'h0,        32'h0,        0, 0, 32'h0,        0);
        step("rst_after",   1,   5,  0,  0, 0,  32'h0,        4'h0,  0,  0,  32'h0,        32'h0,        0, 0, 32'h0,        0);
        step("wr_r7_full",  1,   7,  0,  1, 7,  32'h11223344, 4'hF,  0,  0,  32'h11223344, 32'h0,        0, 0, 32'h0,        0);
        step("wr_r7_bytes", 1,   7,  0,  1, 7,  32'hAABBCCDD, 4'h5,  0,  0,  32'h11BB33DD, 32'h0,        0, 0, 32'h11223344, 0);
        step("rd_r7",       1,   7,  0,  0, 0,  32'h0,        4'h0,  0,  0,  32'h11BB33DD, 32'h0,        0, 0, 32'h11BB33DD, 0);
        step("iss_r9",      1,   9,  0,  0, 0,  32'h0,        4'h0,  1,  9,  32'h0,        32'h0,        0, 0, 32'h0,        0);
        step("busy_r9",     1,   9,  0,  0, 0,  32'h0,        4'h0,  0,  0,  32'h0,        32'h0,        1, 0, 32'h0,        1);
        step("byp_r9",      1,   9,  0,  1, 9,  32'h12345678, 4'hF,  0,  0,  32'h12345678, 32'h0,        0, 0, 32'h0,        1);
        step("rd_r9",       1,   9,  0,  0, 0,  32'h0,        4'h0,  0,  0,  32'h12345678, 32'h0,        0, 0, 32'h12345678, 0);
        step("wr_r0",       1,   0,  0,  1, 0,  32'hFFFFFFFF, 4'hF,  1,  0,  32'h0,        32'h0,        0, 0, 32'h0,        0);
        step("rd_r0",       1,   0,  0,  0, 0,  32'h0,        4'h0,  0,  0,  32'h0,        32'h0,        0, 0, 32'h0,        0);
        step("iss_r3",      1,   3,  0,  0, 0,  32'h0,        4'h0,  1,  3,  32'h0,        32'h0,        0, 0, 32'h0,        0);
        step("busy_r3",     1,   3,  0,  0, 0,  32'h0,        4'h0,  0,  0,  32'h0,        32'h0,        1, 0, 32'h0,        1);
        step("wr_r3",       1,   3,  0,  1, 3,  32'h00000055, 4'hF,  0,  0,  32'h00000055, 32'h0,        0, 0, 32'h0,        1);
        step("clr_r3",      1,   3,  0,  0, 0,  32'h0,        4'h0,  0,  0,  32'h00000055, 32'h0,        0, 0, 32'h00000055, 0);
        step("iss_wr_r3",   1,   3,  0,  1, 3,  32'h00000066, 4'hF,  1,  3,  32'h00000066, 32'h0,        0, 0, 32'h00000055, 0);
        step("set_wins_r3", 1,   3,  0,  0, 0,  32'h0,        4'h0,  0,  0,  32'h00000066, 32'h0,        1, 0, 32'h00000066, 1);
        step("iss4_wr3_be0",1,   3,  4,  1, 3,  32'h00000077, 4'h0,  1,  4,  32'h00000066, 32'h0,        0, 0, 32'h00000066, 1);
        step("both_apply",  1,   3,  4,  0, 0,  32'h0,        4'h0,  0,  0,  32'h00000066, 32'h0,        0, 1, 32'h00000066, 0);
        step("wr_iss_r4",   1,   4,  4,  1, 4,  32'hCAFE0000, 4'hF,  1,  4,  32'hCAFE0000, 32'hCAFE0000, 0, 0, 32'h0,        1);
        step("dual_r4",     1,   4,  4,  0, 0,  32'h0,        4'h0,  0,  0,  32'hCAFE0000, 32'hCAFE0000, 1, 1, 32'hCAFE0000, 1);
        step("rst_mid2",    0,   4,  7,  0, 0,  32'h0,        4'h0,  0,  0,  32'h0,        32'h0,        0, 0, 32'h0,        0);
        step("rst_after2",  1,   4,  7,  0, 0,  32'h0,        4'h0,  0,  0,  32'h0,        32'h0,        0, 0, 32'h0,        0);

        wait_cnt = 0;
        while ((q_exp.size() > 0) && (wait_cnt < 10)) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (q_exp.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q_exp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regfile_bypass_sb
`default_nettype wire
